dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory slave with a valid/ready request/response pair.
// Fixed wait-state latency; faults on misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_enter_resp;

  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wstrb;
  logic            w_err;
  logic [AW-1:0]   w_idx;

  logic [31:0]     r_mem [DEPTH_WORDS];

  // With zero wait states the access completes on the accept edge,
  // so the live request fields are used instead of the captured ones.
  assign w_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_wstrb = (r_state == ST_IDLE) ? req_wstrb : r_wstrb;

  assign w_err = (w_addr[1:0] != 2'b00) ||
                 ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx = w_addr[AW+1:2];

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            w_next    = ST_WAIT;
            w_cnt_nxt = CW'(WAIT_STATES);
          end else begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == ST_IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (w_enter_resp) begin
        if (w_err) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else if (w_we) begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_err   <= 1'b0;
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (w_enter_resp && !w_err && w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
